// File: rtl/wb_dest_router_pkg.sv
// Shared definitions for the writeback destination router: defaults and FSM encoding.
package wb_dest_router_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int REG_AW_DEF  = 4;
  localparam int TIMEOUT_DEF = 15;
  localparam int TMR_W       = 8;  // wide enough for TIMEOUT up to 255

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RF_WR   = 2'd1,
    ST_MEM_REQ = 2'd2
  } state_t;
endpackage

// File: rtl/wb_dest_router_if.sv
// Result-in / register-file / store-request bundle between the pipeline and the router.
interface wb_dest_router_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              dest_select;
  logic [DATA_W-1:0] result;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] st_addr;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              timeout_pulse;
  logic              err_flag;

  modport master (
    output in_valid, dest_select, result, rd_addr, st_addr, mem_ack,
    input  in_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
           timeout_pulse, err_flag
  );

  modport slave (
    input  in_valid, dest_select, result, rd_addr, st_addr, mem_ack,
    output in_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
           timeout_pulse, err_flag
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Store wait counter: counts enabled cycles, flags the TIMEOUT-th one.
module wb_timeout_counter
  import wb_dest_router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (enable && !expired)  cnt <= cnt + 1'b1;
  end

  // cnt holds the number of earlier unacked cycles, so this is the TIMEOUT-th one
  assign expired = (cnt == LAST);
endmodule

// File: rtl/wb_dest_router.sv
// Routes a writeback result either to the register file (1-cycle write) or to
// data memory as a store request with ack timeout and sticky error flag.
module wb_dest_router
  import wb_dest_router_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  wb_dest_router_if.slave  bus
);
  state_t            state, nxt;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] cap_st;
  logic [REG_AW-1:0] cap_rd;
  logic              tmo_q;
  logic              err_q;
  logic              accept;
  logic              tmr_en;
  logic              tmr_expired;
  logic              tmo_fire;

  assign accept   = bus.in_valid && (state != ST_MEM_REQ);
  assign tmr_en   = (state == ST_MEM_REQ) && !bus.mem_ack;
  assign tmo_fire = tmr_en && tmr_expired;  // ack wins over a same-cycle timeout

  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_MEM_REQ),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cap_data <= '0;
      cap_st   <= '0;
      cap_rd   <= '0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= nxt;
      tmo_q <= tmo_fire;
      if (tmo_fire) err_q <= 1'b1;
      if (accept) begin
        cap_data <= bus.result;
        cap_st   <= bus.st_addr;
        cap_rd   <= bus.rd_addr;
      end
    end
  end

  always_comb begin
    nxt               = state;
    bus.in_ready      = 1'b1;
    bus.rf_we         = 1'b0;
    bus.mem_req       = 1'b0;
    bus.rf_waddr      = cap_rd;
    bus.rf_wdata      = cap_data;
    bus.mem_addr      = cap_st;
    bus.mem_wdata     = cap_data;
    bus.timeout_pulse = tmo_q;
    bus.err_flag      = err_q;
    case (state)
      ST_IDLE, ST_RF_WR: begin
        bus.rf_we = (state == ST_RF_WR);
        if (accept) nxt = bus.dest_select ? ST_MEM_REQ : ST_RF_WR;
        else        nxt = ST_IDLE;
      end
      ST_MEM_REQ: begin
        bus.in_ready = 1'b0;
        bus.mem_req  = 1'b1;
        if (bus.mem_ack || tmo_fire) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_dest_router.sv
// Self-checking bench for wb_dest_router: directed stimulus with a write/store scoreboard.
module tb_wb_dest_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } xfer_t;

  xfer_t rf_q[$];
  xfer_t mem_q[$];

  wb_dest_router_if #(.DATA_W(16), .REG_AW(4)) bus ();

  wb_dest_router #(.DATA_W(16), .REG_AW(4), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid    = 1'b0;
    bus.dest_select = 1'($urandom);
    bus.result      = 16'($urandom);
    bus.rd_addr     = 4'($urandom);
    bus.st_addr     = 16'($urandom);
  endtask

  task automatic send_rf(input logic [3:0] a, input logic [15:0] d);
    bus.in_valid    = 1'b1;
    bus.dest_select = 1'b0;
    bus.rd_addr     = a;
    bus.result      = d;
    bus.st_addr     = 16'($urandom);
    rf_q.push_back('{16'(a), d});
  endtask

  task automatic send_st(input logic [15:0] a, input logic [15:0] d, input bit acked);
    bus.in_valid    = 1'b1;
    bus.dest_select = 1'b1;
    bus.st_addr     = a;
    bus.result      = d;
    bus.rd_addr     = 4'($urandom);
    if (acked) mem_q.push_back('{a, d});
  endtask

  // Output monitor: pops the scoreboard on every register write and acked store
  always @(negedge clk) begin
    xfer_t e;
    if (!rst) begin
      if (bus.rf_we) begin
        if (rf_q.size() == 0) chk("rf_unexpected", 32'd1, 32'd0);
        else begin
          e = rf_q.pop_front();
          chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
          chk("rf_wdata", 32'(bus.rf_wdata), 32'(e.data));
        end
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
        else begin
          e = mem_q.pop_front();
          chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
      if (bus.rf_we || bus.mem_req) chk("rf_mem_excl", 32'(bus.rf_we & bus.mem_req), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.mem_ack = 1'b0;
    idle_in();
    repeat (3) step();
    // reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_tmo", 32'(bus.timeout_pulse), 32'd0);
    chk("rst_err", 32'(bus.err_flag), 32'd0);
    chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // single register write
    send_rf(4'h5, 16'h1234);
    step();
    idle_in();
    chk("rf1_we", 32'(bus.rf_we), 32'd1);
    chk("rf1_waddr", 32'(bus.rf_waddr), 32'h5);
    chk("rf1_wdata", 32'(bus.rf_wdata), 32'h1234);
    step();
    chk("rf1_we_off", 32'(bus.rf_we), 32'd0);

    // three back-to-back register writes
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ready_pre", 32'(bus.in_ready), 32'd1);
      send_rf(4'(i + 8), 16'hA000 + 16'(i));
      step();
      chk("b2b_we", 32'(bus.rf_we), 32'd1);
      chk("b2b_ready", 32'(bus.in_ready), 32'd1);
    end
    idle_in();
    step();
    chk("b2b_we_off", 32'(bus.rf_we), 32'd0);

    // stray ack while idle is ignored
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("stray_ack_req", 32'(bus.mem_req), 32'd0);
    chk("stray_ack_ready", 32'(bus.in_ready), 32'd1);

    // store acked on 4th mem_req cycle
    send_st(16'h0040, 16'hBEEF, 1'b1);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("st_req", 32'(bus.mem_req), 32'd1);
      chk("st_ready", 32'(bus.in_ready), 32'd0);
      chk("st_addr", 32'(bus.mem_addr), 32'h0040);
      chk("st_data", 32'(bus.mem_wdata), 32'hBEEF);
      if (i == 3) bus.mem_ack = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    chk("st_done_req", 32'(bus.mem_req), 32'd0);
    chk("st_done_ready", 32'(bus.in_ready), 32'd1);
    chk("st_done_tmo", 32'(bus.timeout_pulse), 32'd0);

    // ack on the 15th wait cycle: ack beats timeout
    send_st(16'h1111, 16'h2222, 1'b1);
    step();
    idle_in();
    for (int i = 0; i < 15; i++) begin
      chk("late_req", 32'(bus.mem_req), 32'd1);
      if (i == 14) bus.mem_ack = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    chk("late_tmo", 32'(bus.timeout_pulse), 32'd0);
    chk("late_err", 32'(bus.err_flag), 32'd0);
    chk("late_req_off", 32'(bus.mem_req), 32'd0);
    step();
    chk("late_tmo2", 32'(bus.timeout_pulse), 32'd0);

    // store never acked: times out after 15 cycles
    send_st(16'h3333, 16'h4444, 1'b0);
    step();
    idle_in();
    for (int i = 0; i < 15; i++) begin
      chk("to_req", 32'(bus.mem_req), 32'd1);
      chk("to_tmo_low", 32'(bus.timeout_pulse), 32'd0);
      step();
    end
    chk("to_req_off", 32'(bus.mem_req), 32'd0);
    chk("to_tmo", 32'(bus.timeout_pulse), 32'd1);
    chk("to_err", 32'(bus.err_flag), 32'd1);
    chk("to_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("to_tmo_off", 32'(bus.timeout_pulse), 32'd0);
    chk("to_err_hold", 32'(bus.err_flag), 32'd1);

    // successful store afterwards leaves err_flag set
    send_st(16'h5555, 16'h6666, 1'b1);
    step();
    idle_in();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("after_err", 32'(bus.err_flag), 32'd1);
    chk("after_req", 32'(bus.mem_req), 32'd0);

    // reset in the 2nd MEM_REQ cycle
    send_st(16'h0080, 16'hCAFE, 1'b0);
    step();
    idle_in();
    step();
    chk("mid_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_err", 32'(bus.err_flag), 32'd0);
    step();
    chk("mid_rst_tmo", 32'(bus.timeout_pulse), 32'd0);
    rst = 1'b0;
    chk("mid_rel_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rel_addr", 32'(bus.mem_addr), 32'd0);
    step();
    chk("mid_rel_tmo", 32'(bus.timeout_pulse), 32'd0);
    chk("mid_rel_req", 32'(bus.mem_req), 32'd0);

    // normal operation resumes
    send_rf(4'h3, 16'h0F0F);
    step();
    idle_in();
    chk("post_we", 32'(bus.rf_we), 32'd1);
    step();
    step();

    chk("rf_q_empty", 32'(rf_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
